// File: rtl/demux1x4_tdm_if.sv
// demux1x4_tdm_if: bundles the serial slot input and the parallel frame
// output of the 1:4 TDM demultiplexer.
//   en, sync, din          : serial side, driven by the master
//   dout, frame_valid, sel : frame side, driven by the slave (demux)
//   locked, sync_err,
//   err_cnt                : alignment status, driven by the slave
interface demux1x4_tdm_if #(
  parameter int unsigned W = 1
);
  logic           en;
  logic           sync;
  logic [W-1:0]   din;
  logic [4*W-1:0] dout;
  logic           frame_valid;
  logic [1:0]     sel;
  logic           locked;
  logic           sync_err;
  logic [3:0]     err_cnt;

  modport master (
    output en, sync, din,
    input  dout, frame_valid, sel, locked, sync_err, err_cnt
  );

  modport slave (
    input  en, sync, din,
    output dout, frame_valid, sel, locked, sync_err, err_cnt
  );
endinterface

// File: rtl/demux1x4_tdm.sv
// demux1x4_tdm: receive end of a 4:1 slot-multiplexed link. Aligns to the
// frame marker, collects slots 0..3 into shadow registers and publishes
// each complete frame on dout with a one-cycle frame_valid strobe.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of demux1x4_tdm_if (en/sync/din in; dout,
//         frame_valid, sel, locked, sync_err, err_cnt out, all registered)
module demux1x4_tdm #(
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst,
  demux1x4_tdm_if.slave  bus
);

  localparam int unsigned SLOTS   = 4;
  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [W-1:0]         sh_q [3];
  logic [W-1:0]         sh_d [3];
  logic [SLOTS*W-1:0]   dout_q, dout_d;
  logic                 fv_q, fv_d;
  logic                 se_q, se_d;
  logic                 locked_q, locked_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      sel_q    <= 2'd0;
      for (int i = 0; i < 3; i++) sh_q[i] <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
      se_q     <= 1'b0;
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      for (int i = 0; i < 3; i++) sh_q[i] <= sh_d[i];
      dout_q   <= dout_d;
      fv_q     <= fv_d;
      se_q     <= se_d;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: alignment, slot storage and frame completion
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    for (int i = 0; i < 3; i++) sh_d[i] = sh_q[i];
    dout_d  = dout_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      HUNT: begin
        if (bus.en && bus.sync) begin
          sh_d[0] = bus.din;
          sel_d   = 2'd1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (bus.en) begin
          if (bus.sync && (sel_q != 2'd0)) begin
            // Misplaced marker: drop the partial frame and realign here
            sh_d[0] = bus.din;
            sel_d   = 2'd1;
            se_d    = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            unique case (sel_q)
              2'd0: sh_d[0] = bus.din;
              2'd1: sh_d[1] = bus.din;
              2'd2: sh_d[2] = bus.din;
              2'd3: begin
                dout_d = {bus.din, sh_q[2], sh_q[1], sh_q[0]};
                fv_d   = 1'b1;
              end
            endcase
            sel_d = sel_q + 2'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    locked_d = (state_d == LOCKED);
  end

  assign bus.dout        = dout_q;
  assign bus.frame_valid = fv_q;
  assign bus.sel         = sel_q;
  assign bus.locked      = locked_q;
  assign bus.sync_err    = se_q;
  assign bus.err_cnt     = cnt_q;

endmodule

// File: tb/tb_demux1x4_tdm.sv
// tb_demux1x4_tdm: drives a W=4 and a W=1 demux with the same slot stream
// (the W=1 instance sees bit 0 of each sample) and compares both against a
// queue-based frame model every cycle.
module tb_demux1x4_tdm;

  logic clk;
  logic rst;

  demux1x4_tdm_if #(.W(4)) b4 ();
  demux1x4_tdm_if #(.W(1)) b1 ();

  demux1x4_tdm #(.W(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  demux1x4_tdm #(.W(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a frame is simply the list of samples gathered since
  // the last accepted marker or completed frame.
  bit         m_locked;
  logic [3:0] m_part[$];
  logic [15:0] m_dout;
  bit         m_fv;
  bit         m_se;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_part.delete();
    m_dout = '0;
    m_fv = 0;
    m_se = 0;
    m_cnt = 0;
  endtask

  task automatic model_update(input bit e, input bit s, input logic [3:0] d);
    m_fv = 0;
    m_se = 0;
    if (e) begin
      if (!m_locked) begin
        if (s) begin
          m_locked = 1;
          m_part.delete();
          m_part.push_back(d);
        end
      end else if (s && m_part.size() != 0) begin
        m_se = 1;
        if (m_cnt < 15) m_cnt++;
        m_part.delete();
        m_part.push_back(d);
      end else begin
        m_part.push_back(d);
        if (m_part.size() == 4) begin
          m_dout = {m_part[3], m_part[2], m_part[1], m_part[0]};
          m_fv = 1;
          m_part.delete();
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] exp1;
    exp1 = {m_dout[12], m_dout[8], m_dout[4], m_dout[0]};
    check("dout4",     32'(b4.dout),        32'(m_dout));
    check("fv4",       32'(b4.frame_valid), 32'(m_fv));
    check("sel4",      32'(b4.sel),         32'(m_part.size()));
    check("locked4",   32'(b4.locked),      32'(m_locked));
    check("sync_err4", 32'(b4.sync_err),    32'(m_se));
    check("err_cnt4",  32'(b4.err_cnt),     32'(m_cnt));
    check("dout1",     32'(b1.dout),        32'(exp1));
    check("fv1",       32'(b1.frame_valid), 32'(m_fv));
    check("sel1",      32'(b1.sel),         32'(m_part.size()));
    check("locked1",   32'(b1.locked),      32'(m_locked));
    check("err_cnt1",  32'(b1.err_cnt),     32'(m_cnt));
  endtask

  task automatic drive(input bit e, input bit s, input logic [3:0] d);
    b4.en = e; b4.sync = s; b4.din = d;
    b1.en = e; b1.sync = s; b1.din = d[0];
  endtask

  // One clock: apply inputs, advance, update model, compare after the edge
  task automatic step(input bit e, input bit s, input logic [3:0] d);
    drive(e, s, d);
    @(posedge clk);
    model_update(e, s, d);
    #1;
    compare_all();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
  task automatic pulse_reset();
    drive(1'b0, 1'b0, 4'h0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_locked_now", 32'(b4.locked), 32'd0);
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  int fvc;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("reset_dout", 32'(b4.dout), 32'd0);
    rst = 1'b0;

    // Reset mid-stream, then hunting without a marker
    for (int i = 0; i < 8; i++)
      step(1'b1, ($urandom_range(0, 2) == 0), 4'($urandom));
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 4'($urandom));
      check("hunt_locked", 32'(b1.locked), 32'd0);
      check("hunt_fv", 32'(b1.frame_valid), 32'd0);
    end

    // Basic frame, W=1 view: 1,0,1,1 -> 4'b1101
    step(1'b1, 1'b1, 4'h1);
    check("basic_locked", 32'(b1.locked), 32'd1);
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h1);
    step(1'b1, 1'b0, 4'h1);
    check("basic_dout", 32'(b1.dout), 32'hD);
    check("basic_fv", 32'(b1.frame_valid), 32'd1);
    step(1'b0, 1'b0, 4'h0);
    check("basic_fv_off", 32'(b1.frame_valid), 32'd0);

    // Gapped enable, W=4: 1,2,3,4 with two idle cycles between samples
    fvc = 0;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, (k == 1), 4'(k));
      fvc += int'(b4.frame_valid);
      if (k < 4) begin
        for (int g = 0; g < 2; g++) begin
          step(1'b0, 1'b1, 4'hF);
          check("gap_sel_hold", 32'(b4.sel), 32'(k));
          fvc += int'(b4.frame_valid);
        end
      end
    end
    step(1'b0, 1'b0, 4'h0);
    fvc += int'(b4.frame_valid);
    check("gap_dout", 32'(b4.dout), 32'h4321);
    check("gap_fv_count", 32'(fvc), 32'd1);

    // Misplaced sync: A,B dropped, frame becomes {F,E,D,C}
    step(1'b1, 1'b0, 4'hA);
    step(1'b1, 1'b0, 4'hB);
    step(1'b1, 1'b1, 4'hC);
    check("mis_sync_err", 32'(b4.sync_err), 32'd1);
    check("mis_err_cnt", 32'(b4.err_cnt), 32'd1);
    step(1'b1, 1'b0, 4'hD);
    check("mis_sync_err_off", 32'(b4.sync_err), 32'd0);
    step(1'b1, 1'b0, 4'hE);
    step(1'b1, 1'b0, 4'hF);
    check("mis_dout", 32'(b4.dout), 32'hFEDC);
    check("mis_fv", 32'(b4.frame_valid), 32'd1);

    // Saturation: 17 more misplaced markers
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, 4'($urandom));
      step(1'b1, 1'b1, 4'($urandom));
      check("sat_sync_err", 32'(b4.sync_err), 32'd1);
    end
    check("sat_err_cnt", 32'(b4.err_cnt), 32'd15);
    step(1'b1, 1'b1, 4'h3);
    check("sat_err_cnt_hold", 32'(b4.err_cnt), 32'd15);

    // Reset mid-frame, then fresh frame 0,1,0,1 -> 4'b1010
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h1);
    pulse_reset();
    step(1'b1, 1'b1, 4'h0);
    step(1'b1, 1'b0, 4'h1);
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h1);
    check("rmf_dout", 32'(b1.dout), 32'hA);
    check("rmf_err_cnt", 32'(b1.err_cnt), 32'd0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) pulse_reset();
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 6) == 0), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/demux1x4_tdm.md
# demux1x4_tdm

Time-division 1-to-4 demultiplexer: the receive end of the 4:1 slot-multiplexed link. A serial channel carries one W-bit sample per enabled cycle, in slot order 0,1,2,3. The block aligns to a frame marker and distributes each slot's sample to its own lane of a parallel output word. It presents complete frames with a one-cycle valid strobe and counts alignment errors.

## Interface
- W, default 1: data width of one slot/channel.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample qualifier; `din`/`sync` are only looked at when `en`=1.
- sync  in  1  frame marker; high with `en` marks the current sample as slot 0.
- din  in  W  serial slot data.
- dout  out  4*W  last complete frame; slot k occupies `dout[k*W +: W]` (same slot-to-lane mapping as the 4:1 mux `din[sel]`).
- frame_valid  out  1  one-cycle pulse: `dout` was just updated with a new frame.
- sel  out  2  slot index the next enabled sample will be stored as.
- locked  out  1  1 when aligned (LOCKED state).
- sync_err  out  1  one-cycle pulse: `sync` seen at a slot other than 0 while locked.
- err_cnt  out  4  saturating count of `sync_err` events (sticks at 15).

## Operation
- **FSM states:** HUNT and LOCKED. Reset enters HUNT.
- **HUNT:**
  - Enabled samples without `sync` are discarded; `sel` is held at 0.
  - `en`&`sync` stores `din` as slot 0, sets `sel`=1, and moves to LOCKED.
- **LOCKED:**
  - Each `en` cycle stores `din` into shadow register `sh[sel]`, then `sel` increments mod 4.
  - Cycles with `en`=0 change nothing.
- **Frame completion:**
  - The enabled sample stored with `sel`=3 completes the frame.
  - At that edge, `dout` gets {`din`, `sh[2]`, `sh[1]`, `sh[0]`}, `frame_valid` pulses, and `sel` wraps to 0.
- **Sync while locked:**
  - `sync` at `sel`=0 is legal and silent.
  - `sync` is optional once locked; free-running frames continue without it.
- **Misplaced sync (LOCKED, `en`&`sync`, `sel`≠0):**
  - The partial frame is discarded; `dout` is not updated and `frame_valid` is not asserted.
  - The current `din` is stored as slot 0 and `sel` becomes 1.
  - `sync_err` pulses.
  - `err_cnt` increments unless it is already 15.
  - The block stays in LOCKED.
- **`sync` with `en`=0:** ignored in both states.
- **Outputs:** `dout` holds its value between frames. Shadow registers are internal and are never exposed partially.

## Timing
- All state is registered on the `clk` rising edge. No combinational path from inputs to outputs.
- **Latency:** `dout` and `frame_valid` appear 1 cycle after the edge that samples slot 3.
- `sel`, `locked`, `sync_err` and `err_cnt` reflect the sampling edge and are visible the following cycle.
- Back-to-back frames with continuous `en` give `frame_valid` every 4th cycle.
- `frame_valid` and `sync_err` are never high in the same cycle.
- **Reset values:** `dout`=0, `frame_valid`=0, `sel`=0, `locked`=0, `sync_err`=0, `err_cnt`=0; shadow registers 0; state HUNT.
- **Reset mid-frame:** asynchronous reset immediately clears all of the above. The partial frame is lost and the block re-hunts.
- `err_cnt` is cleared only by `rst`.

## Test plan
- **Reset and hunt:** assert `rst` mid-stream, then feed 6 enabled samples with `sync`=0.
  - Required: all outputs stay at reset values and `locked`=0 throughout.
- **Basic frame (W=1):**
  - Stimulus: `en`=1 continuous, `sync`=1 with `din`=1, then `din`=0,1,1.
  - Required: `locked`=1 after the first edge; `dout`=4'b1101 and `frame_valid`=1 one cycle after the 4th sample, then `frame_valid`=0.
- **Gapped enable (W=4):**
  - Stimulus: slots 0x1,0x2,0x3,0x4 with `en` low for 2 cycles between each.
  - Required: `dout`=16'h4321; exactly one `frame_valid` pulse; `sel` holds its value during the gaps.
- **Misplaced sync:**
  - Stimulus: after lock, 2 samples (A,B), then `sync` with C, then D,E,F.
  - Required: `sync_err` pulses once and `err_cnt`=1; no frame containing A/B; the next frame is {F,E,D,C}.
- **Saturation:** force 17 misplaced syncs.
  - Required: `err_cnt` reaches 15 and stays at 15; `sync_err` still pulses every time.
- **Reset mid-frame:**
  - Stimulus: lock, store 2 slots, pulse `rst`, then a fresh synced frame 0,1,0,1 (W=1).
  - Required: `locked`=0 immediately on reset; the next `dout`=4'b1010 with no stale bits.
